// File: rtl/cpu_mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between the D-cache and I-refill ports.
// Each transaction owns the port until all response beats return; a timeout closes it out with error beats.
module cpu_mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int LEN_W   = 3,
  parameter int TIMEOUT = 1023
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              d_cmd_valid,
  output logic              d_cmd_ready,
  input  logic              d_cmd_wr,
  input  logic [ADDR_W-1:0] d_cmd_addr,
  input  logic [DATA_W-1:0] d_cmd_wdata,
  input  logic [LEN_W-1:0]  d_cmd_len,
  output logic              d_rsp_valid,
  output logic [DATA_W-1:0] d_rsp_rdata,
  output logic              d_rsp_error,
  input  logic              i_cmd_valid,
  output logic              i_cmd_ready,
  input  logic [ADDR_W-1:0] i_cmd_addr,
  input  logic [LEN_W-1:0]  i_cmd_len,
  output logic              i_rsp_valid,
  output logic [DATA_W-1:0] i_rsp_rdata,
  output logic              i_rsp_error,
  output logic              mem_cmd_valid,
  input  logic              mem_cmd_ready,
  output logic              mem_cmd_wr,
  output logic [ADDR_W-1:0] mem_cmd_addr,
  output logic [DATA_W-1:0] mem_cmd_wdata,
  output logic [LEN_W-1:0]  mem_cmd_len,
  input  logic              mem_rsp_valid,
  input  logic [DATA_W-1:0] mem_rsp_rdata,
  input  logic              mem_rsp_error,
  output logic [1:0]        grant,
  output logic              timeout_pulse,
  output logic              spurious_rsp
);

  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0]  TMAX    = TW'(TIMEOUT);
  localparam logic [TW-1:0]  TONE    = TW'(1);
  localparam logic [LEN_W:0] CNT_ONE = (LEN_W+1)'(1);

  typedef enum logic [1:0] {IDLE, CMD, RSP, FLUSH} state_t;

  state_t           state, state_nx;
  logic [1:0]       grant_nx;
  logic             last, last_nx;   // 1 = I-port owned the previous transaction
  logic [LEN_W:0]   cnt, cnt_nx;
  logic [TW-1:0]    timer, timer_nx;
  logic             own_i, rsp_go, rsp_err, tmo_fire, pick_i;
  logic [DATA_W-1:0] rsp_data;

  assign own_i = grant[1];

  // Command and response paths are pure muxes on the registered grant.
  always_comb begin
    mem_cmd_wr    = ~own_i & d_cmd_wr;
    mem_cmd_addr  = own_i ? i_cmd_addr : d_cmd_addr;
    mem_cmd_wdata = own_i ? '0 : d_cmd_wdata;
    mem_cmd_len   = own_i ? i_cmd_len : (d_cmd_wr ? '0 : d_cmd_len);
    mem_cmd_valid = (state == CMD) && (own_i ? i_cmd_valid : d_cmd_valid);
    d_cmd_ready   = (state == CMD) && grant[0] && mem_cmd_ready;
    i_cmd_ready   = (state == CMD) && grant[1] && mem_cmd_ready;
    rsp_go        = ((state == RSP) && mem_rsp_valid) || (state == FLUSH);
    rsp_data      = (state == FLUSH) ? '0 : mem_rsp_rdata;
    rsp_err       = (state == FLUSH) ? 1'b1 : mem_rsp_error;
    d_rsp_valid   = rsp_go && grant[0];
    d_rsp_rdata   = rsp_data;
    d_rsp_error   = rsp_err;
    i_rsp_valid   = rsp_go && grant[1];
    i_rsp_rdata   = rsp_data;
    i_rsp_error   = rsp_err;
    // A beat landing on the deadline cycle still counts as progress.
    tmo_fire      = (TIMEOUT != 0) && (state == RSP) && !mem_rsp_valid && (timer == TMAX);
    timeout_pulse = tmo_fire;
  end

  always_comb begin
    state_nx = state;
    grant_nx = grant;
    last_nx  = last;
    cnt_nx   = cnt;
    timer_nx = timer;
    pick_i   = i_cmd_valid && (!d_cmd_valid || !last);
    case (state)
      IDLE: if (d_cmd_valid || i_cmd_valid) begin
        grant_nx = pick_i ? 2'b10 : 2'b01;
        state_nx = CMD;
      end
      CMD: if (mem_cmd_valid && mem_cmd_ready) begin
        cnt_nx   = own_i ? ({1'b0, i_cmd_len} + CNT_ONE)
                         : (d_cmd_wr ? CNT_ONE : ({1'b0, d_cmd_len} + CNT_ONE));
        timer_nx = '0;
        state_nx = RSP;
      end
      RSP: if (mem_rsp_valid) begin
        timer_nx = '0;
        cnt_nx   = cnt - CNT_ONE;
        if (cnt <= CNT_ONE) begin
          state_nx = IDLE;
          last_nx  = grant[1];
          grant_nx = 2'b00;
        end
      end else if (tmo_fire) begin
        state_nx = FLUSH;
      end else if (timer != TMAX) begin
        timer_nx = timer + TONE;
      end
      FLUSH: begin
        cnt_nx = cnt - CNT_ONE;
        if (cnt <= CNT_ONE) begin
          state_nx = IDLE;
          last_nx  = grant[1];
          grant_nx = 2'b00;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      grant        <= 2'b00;
      last         <= 1'b1;
      cnt          <= '0;
      timer        <= '0;
      spurious_rsp <= 1'b0;
    end else begin
      state        <= state_nx;
      grant        <= grant_nx;
      last         <= last_nx;
      cnt          <= cnt_nx;
      timer        <= timer_nx;
      spurious_rsp <= spurious_rsp | (mem_rsp_valid && (state != RSP));
    end
  end

endmodule

// File: tb/tb_cpu_mem_port_arbiter.sv
// Self-checking bench: drives both requesters and the memory side, predicting ownership
// with a round-robin model and checking command/response routing beat by beat.
module tb_cpu_mem_port_arbiter;
  logic        clk = 0, reset = 0;
  logic        d_cmd_valid = 0, d_cmd_ready, d_cmd_wr = 0;
  logic [31:0] d_cmd_addr = 0, d_cmd_wdata = 0;
  logic [2:0]  d_cmd_len = 0;
  logic        d_rsp_valid, d_rsp_error;
  logic [31:0] d_rsp_rdata;
  logic        i_cmd_valid = 0, i_cmd_ready;
  logic [31:0] i_cmd_addr = 0;
  logic [2:0]  i_cmd_len = 0;
  logic        i_rsp_valid, i_rsp_error;
  logic [31:0] i_rsp_rdata;
  logic        mem_cmd_valid, mem_cmd_ready = 0, mem_cmd_wr;
  logic [31:0] mem_cmd_addr, mem_cmd_wdata;
  logic [2:0]  mem_cmd_len;
  logic        mem_rsp_valid = 0, mem_rsp_error = 0;
  logic [31:0] mem_rsp_rdata = 0;
  logic [1:0]  grant;
  logic        timeout_pulse, spurious_rsp;

  int checks = 0, failures = 0;
  int last_m = 1;  // model: requester that owned the previous transaction (0=D, 1=I)

  cpu_mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .LEN_W(3), .TIMEOUT(8)) dut (
    .clk(clk), .reset(reset),
    .d_cmd_valid(d_cmd_valid), .d_cmd_ready(d_cmd_ready), .d_cmd_wr(d_cmd_wr),
    .d_cmd_addr(d_cmd_addr), .d_cmd_wdata(d_cmd_wdata), .d_cmd_len(d_cmd_len),
    .d_rsp_valid(d_rsp_valid), .d_rsp_rdata(d_rsp_rdata), .d_rsp_error(d_rsp_error),
    .i_cmd_valid(i_cmd_valid), .i_cmd_ready(i_cmd_ready), .i_cmd_addr(i_cmd_addr),
    .i_cmd_len(i_cmd_len), .i_rsp_valid(i_rsp_valid), .i_rsp_rdata(i_rsp_rdata),
    .i_rsp_error(i_rsp_error), .mem_cmd_valid(mem_cmd_valid), .mem_cmd_ready(mem_cmd_ready),
    .mem_cmd_wr(mem_cmd_wr), .mem_cmd_addr(mem_cmd_addr), .mem_cmd_wdata(mem_cmd_wdata),
    .mem_cmd_len(mem_cmd_len), .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata),
    .mem_rsp_error(mem_rsp_error), .grant(grant), .timeout_pulse(timeout_pulse),
    .spurious_rsp(spurious_rsp)
  );

  always #5 clk = ~clk;

  task automatic raise_d(input logic wr, input logic [31:0] a, input logic [31:0] wd, input logic [2:0] l);
    d_cmd_valid = 1; d_cmd_wr = wr; d_cmd_addr = a; d_cmd_wdata = wd; d_cmd_len = l;
  endtask

  task automatic raise_i(input logic [31:0] a, input logic [2:0] l);
    i_cmd_valid = 1; i_cmd_addr = a; i_cmd_len = l;
  endtask

  // Entered just after a negedge with the DUT idle and requests driven; returns at a negedge, idle.
  task automatic do_txn(input int rdly, input int gapmax, output int owner);
    logic [1:0] eg; logic ewr; logic [31:0] ea, ewd, wd, rd; logic [2:0] el; logic er; int nb, gaps;
    if (d_cmd_valid && i_cmd_valid) owner = (last_m == 0) ? 1 : 0;
    else owner = d_cmd_valid ? 0 : 1;
    eg  = (owner == 1) ? 2'b10 : 2'b01;
    ewr = (owner == 1) ? 1'b0 : d_cmd_wr;
    ea  = (owner == 1) ? i_cmd_addr : d_cmd_addr;
    ewd = (owner == 1) ? 32'h0 : d_cmd_wdata;
    el  = (owner == 1) ? i_cmd_len : (d_cmd_wr ? 3'd0 : d_cmd_len);
    nb  = ewr ? 1 : int'(el) + 1;
    #1;
    checks++;
    if ({grant, mem_cmd_valid, d_cmd_ready, i_cmd_ready} !== 5'b0) begin
      failures++; $display("FAIL idle_cycle got=%b exp=00000", {grant, mem_cmd_valid, d_cmd_ready, i_cmd_ready});
    end
    for (int c = 0; c <= rdly; c++) begin
      @(negedge clk); mem_cmd_ready = (c == rdly); #1;
      wd = (owner == 1) ? 32'h0 : mem_cmd_wdata;
      checks++;
      if ({grant, mem_cmd_valid, mem_cmd_wr, mem_cmd_addr, wd, mem_cmd_len} !== {eg, 1'b1, ewr, ea, ewd, el}) begin
        failures++;
        $display("FAIL cmd_fields got=%b %b %b %h %h %0d exp=%b 1 %b %h %h %0d",
                 grant, mem_cmd_valid, mem_cmd_wr, mem_cmd_addr, wd, mem_cmd_len, eg, ewr, ea, ewd, el);
      end
      checks++;
      if ({i_cmd_ready, d_cmd_ready} !== ((c == rdly) ? eg : 2'b00)) begin
        failures++; $display("FAIL cmd_ready got=%b exp=%b", {i_cmd_ready, d_cmd_ready}, (c == rdly) ? eg : 2'b00);
      end
    end
    @(negedge clk); mem_cmd_ready = 0;
    if (owner == 1) i_cmd_valid = 0; else d_cmd_valid = 0;
    for (int b = 0; b < nb; b++) begin
      gaps = $urandom_range(gapmax, 0);
      for (int g = 0; g < gaps; g++) begin
        #1; checks++;
        if ({i_rsp_valid, d_rsp_valid} !== 2'b00) begin
          failures++; $display("FAIL rsp_gap got=%b exp=00", {i_rsp_valid, d_rsp_valid});
        end
        @(negedge clk);
      end
      rd = $urandom; er = ($urandom_range(3, 0) == 0);
      mem_rsp_valid = 1; mem_rsp_rdata = rd; mem_rsp_error = er; #1;
      checks++;
      if ({i_rsp_valid, d_rsp_valid} !== eg) begin
        failures++; $display("FAIL rsp_route beat=%0d got=%b exp=%b", b, {i_rsp_valid, d_rsp_valid}, eg);
      end
      checks++;
      if ({(owner == 1) ? i_rsp_rdata : d_rsp_rdata, (owner == 1) ? i_rsp_error : d_rsp_error} !== {rd, er}) begin
        failures++; $display("FAIL rsp_data beat=%0d got=%h/%b exp=%h/%b", b,
                             (owner == 1) ? i_rsp_rdata : d_rsp_rdata, (owner == 1) ? i_rsp_error : d_rsp_error, rd, er);
      end
      @(negedge clk); mem_rsp_valid = 0; mem_rsp_error = 0;
    end
    last_m = owner;
    #1; checks++;
    if ({grant, timeout_pulse} !== 3'b000) begin
      failures++; $display("FAIL txn_end got=%b exp=000", {grant, timeout_pulse});
    end
  endtask

  task automatic test_reset();
    reset = 1; @(negedge clk); @(negedge clk); #1;
    checks++;
    if ({grant, mem_cmd_valid, d_cmd_ready, i_cmd_ready, d_rsp_valid, i_rsp_valid, timeout_pulse, spurious_rsp} !== 9'b0) begin
      failures++; $display("FAIL reset_state got=%b exp=0",
        {grant, mem_cmd_valid, d_cmd_ready, i_cmd_ready, d_rsp_valid, i_rsp_valid, timeout_pulse, spurious_rsp});
    end
    reset = 0; last_m = 1; @(negedge clk);
  endtask

  task automatic test_contention();
    int o;
    reset = 1; @(negedge clk); reset = 0; last_m = 1;
    raise_d(0, $urandom, 0, 3'($urandom)); raise_i($urandom, 3'($urandom));
    for (int k = 0; k < 4; k++) begin
      do_txn(0, 1, o);
      checks++;
      if (o != (k % 2)) begin failures++; $display("FAIL contention_order k=%0d got=%0d exp=%0d", k, o, k % 2); end
      if (k < 2) begin
        if (o == 0) raise_d(0, $urandom, 0, 3'($urandom)); else raise_i($urandom, 3'($urandom));
      end
    end
  endtask

  task automatic test_single_read();
    int o;
    raise_d(0, 32'h100, 32'h0, 3'd3);
    do_txn(0, 0, o);
    checks++;
    if (o != 0) begin failures++; $display("FAIL single_read_owner got=%0d exp=0", o); end
  endtask

  task automatic test_write();
    int o;
    raise_d(1, $urandom, $urandom, 3'd5);
    do_txn(1, 2, o);
  endtask

  task automatic test_backpressure();
    int o;
    raise_d(0, $urandom, 0, 3'($urandom)); raise_i($urandom, 3'($urandom));
    do_txn(5, 1, o);
    do_txn(5, 1, o);
  endtask

  task automatic test_random();
    int o;
    for (int n = 0; n < 25; n++) begin
      if (!d_cmd_valid && $urandom_range(1, 0) == 1) raise_d(1'($urandom), $urandom, $urandom, 3'($urandom));
      if (!i_cmd_valid && $urandom_range(1, 0) == 1) raise_i($urandom, 3'($urandom));
      if (!d_cmd_valid && !i_cmd_valid) raise_d(1'($urandom), $urandom, $urandom, 3'($urandom));
      do_txn($urandom_range(3, 0), $urandom_range(4, 0), o);
    end
    if (d_cmd_valid || i_cmd_valid) do_txn(0, 0, o);
  endtask

  task automatic test_timeout();
    raise_d(0, $urandom, 0, 3'd7); mem_cmd_ready = 1;
    @(negedge clk); @(negedge clk); d_cmd_valid = 0; mem_cmd_ready = 0;
    for (int b = 0; b < 3; b++) begin
      mem_rsp_valid = 1; mem_rsp_rdata = $urandom; #1;
      checks++;
      if (d_rsp_valid !== 1'b1) begin failures++; $display("FAIL tmo_beat b=%0d got=%b exp=1", b, d_rsp_valid); end
      @(negedge clk); mem_rsp_valid = 0;
    end
    for (int s = 0; s < 8; s++) begin
      #1; checks++;
      if ({timeout_pulse, d_rsp_valid} !== 2'b00) begin
        failures++; $display("FAIL tmo_wait s=%0d got=%b exp=00", s, {timeout_pulse, d_rsp_valid});
      end
      @(negedge clk);
    end
    #1; checks++;
    if (timeout_pulse !== 1'b1) begin failures++; $display("FAIL tmo_pulse got=%b exp=1", timeout_pulse); end
    @(negedge clk);
    for (int f = 0; f < 5; f++) begin
      #1; checks++;
      if ({d_rsp_valid, d_rsp_error, d_rsp_rdata, i_rsp_valid, timeout_pulse} !== {1'b1, 1'b1, 32'h0, 1'b0, 1'b0}) begin
        failures++; $display("FAIL tmo_flush f=%0d got=%b %b %h %b %b exp=1 1 0 0 0", f,
                             d_rsp_valid, d_rsp_error, d_rsp_rdata, i_rsp_valid, timeout_pulse);
      end
      @(negedge clk);
    end
    #1; checks++;
    if ({grant, d_rsp_valid} !== 3'b000) begin failures++; $display("FAIL tmo_end got=%b exp=000", {grant, d_rsp_valid}); end
    last_m = 0;
  endtask

  task automatic test_spurious();
    checks++;
    if (spurious_rsp !== 1'b0) begin failures++; $display("FAIL spur_pre got=%b exp=0", spurious_rsp); end
    mem_rsp_valid = 1; mem_rsp_rdata = $urandom; #1;
    checks++;
    if ({d_rsp_valid, i_rsp_valid} !== 2'b00) begin failures++; $display("FAIL spur_fwd got=%b exp=00", {d_rsp_valid, i_rsp_valid}); end
    @(negedge clk); mem_rsp_valid = 0;
    repeat (3) @(negedge clk);
    #1; checks++;
    if (spurious_rsp !== 1'b1) begin failures++; $display("FAIL spur_sticky got=%b exp=1", spurious_rsp); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    raise_d(0, $urandom, 0, 3'd3); mem_cmd_ready = 1;
    @(negedge clk); @(negedge clk); d_cmd_valid = 0; mem_cmd_ready = 0;
    mem_rsp_valid = 1; @(negedge clk); mem_rsp_valid = 0;
    reset = 1; @(negedge clk); reset = 0; last_m = 1; #1;
    checks++;
    if ({grant, spurious_rsp} !== 3'b000) begin failures++; $display("FAIL rst_mid got=%b exp=000", {grant, spurious_rsp}); end
    for (int b = 0; b < 3; b++) begin
      @(negedge clk); mem_rsp_valid = 1; #1;
      checks++;
      if ({d_rsp_valid, i_rsp_valid} !== 2'b00) begin
        failures++; $display("FAIL rst_mid_beat b=%0d got=%b exp=00", b, {d_rsp_valid, i_rsp_valid});
      end
    end
    @(negedge clk); mem_rsp_valid = 0;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_contention();
    test_single_read();
    test_write();
    test_backpressure();
    test_random();
    test_timeout();
    @(negedge clk);
    test_spurious();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
